pc_next_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 31 +++
 rtl/pc_next_unit_if.sv | 38 +++
 rtl/sat_counter.sv | 21 ++
 rtl/pc_next_unit.sv | 115 +++++++++++
 tb/tb_pc_next_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants used by the PC unit, ALU and controller,
// plus the next-PC source selector and branch offset helper.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    localparam logic [5:0] FN_JR     = 6'h08;

    localparam logic [4:0] RT_BLTZ   = 5'd0;
    localparam logic [4:0] RT_BGEZ   = 5'd1;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR
    } pc_sel_e;

    // Sign-extended word offset of a branch immediate.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Bus between the control/datapath side and the PC stage: instruction
// fields, ALU flags and commit strobe in; PC, link address and status out.
interface pc_next_unit_if #(
    parameter int CNT_W = 16
);
    logic             pc_we;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rt;
    logic [15:0]      imm16;
    logic [25:0]      target26;
    logic [31:0]      rs_val;
    logic             gtz, ne, eq, gez, lez, ltz;
    logic             err_clr;

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic [31:0]      link_addr;
    logic             taken;
    logic             addr_err;
    logic [31:0]      err_pc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output pc_we, opcode, funct, rt, imm16, target26, rs_val,
               gtz, ne, eq, gez, lez, ltz, err_clr,
        input  pc, pc_plus4, link_addr, taken, addr_err, err_pc,
               br_cnt, taken_cnt
    );

    modport slave (
        input  pc_we, opcode, funct, rt, imm16, target26, rs_val,
               gtz, ne, eq, gez, lez, ltz, err_clr,
        output pc, pc_plus4, link_addr, taken, addr_err, err_pc,
               br_cnt, taken_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// PC stage of the multi-cycle MIPS: picks the next PC from branch/jump
// decode and ALU flags, commits on pc_we, traps misaligned targets.
module pc_next_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_next_unit_if.slave bus
);

    logic [31:0] pc_q;
    logic [31:0] err_pc_q;
    logic        taken_q;
    logic        addr_err_q;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    pc_sel_e     sel;
    logic        is_branch;
    logic        cond;
    logic        commit;
    logic        misaligned;

    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statements can leave one unassigned (no latches).
    always_comb begin
        is_branch = 1'b0;
        cond      = 1'b0;
        sel       = SEL_SEQ;
        next_pc   = pc_plus4;

        unique case (bus.opcode)
            OP_BEQ:  begin is_branch = 1'b1; cond = bus.eq;  end
            OP_BNE:  begin is_branch = 1'b1; cond = bus.ne;  end
            OP_BLEZ: begin is_branch = 1'b1; cond = bus.lez; end
            OP_BGTZ: begin is_branch = 1'b1; cond = bus.gtz; end
            OP_REGIMM: begin
                if (bus.rt == RT_BGEZ) begin
                    is_branch = 1'b1;
                    cond      = bus.gez;
                end else if (bus.rt == RT_BLTZ) begin
                    is_branch = 1'b1;
                    cond      = bus.ltz;
                end
            end
            OP_J, OP_JAL: sel = SEL_JUMP;
            OP_RTYPE: if (bus.funct == FN_JR) sel = SEL_JR;
            default: ;
        endcase

        if (is_branch && cond) sel = SEL_BRANCH;

        unique case (sel)
            SEL_BRANCH: next_pc = pc_plus4 + branch_offset(bus.imm16);
            SEL_JUMP:   next_pc = {pc_plus4[31:28], bus.target26, 2'b00};
            SEL_JR:     next_pc = bus.rs_val;
            default:    next_pc = pc_plus4;
        endcase
    end

    // A pending error blocks commits; a clear in the same cycle also drops it.
    assign commit     = bus.pc_we && !addr_err_q && !bus.err_clr;
    assign misaligned = (next_pc[1:0] != 2'b00);

    // NOTE: asynchronous active-low reset; the sensitivity list carries
    // negedge rst_n so reset takes effect without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            taken_q    <= 1'b0;
            addr_err_q <= 1'b0;
            err_pc_q   <= '0;
        end else begin
            taken_q <= 1'b0;
            if (bus.err_clr) begin
                addr_err_q <= 1'b0;
            end else if (commit) begin
                if (misaligned) begin
                    addr_err_q <= 1'b1;
                    err_pc_q   <= pc_q;
                end else begin
                    pc_q    <= next_pc;
                    taken_q <= (sel != SEL_SEQ);
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (commit && !misaligned && is_branch),
        .count (bus.br_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (commit && !misaligned && is_branch && cond),
        .count (bus.taken_cnt)
    );

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.link_addr = pc_q + 32'd8;
    assign bus.taken     = taken_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.err_pc    = err_pc_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed plus randomized bench for pc_next_unit against an arithmetic
// reference model of the next-PC rules.
module tb_pc_next_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          CW     = 2;
    localparam int          CMAX   = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    pc_next_unit_if #(.CNT_W(CW)) bus ();

    pc_next_unit #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [31:0] m_pc, m_err_pc;
    logic        m_taken, m_err;
    int          m_br, m_tk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_err_pc = '0; m_taken = 1'b0; m_err = 1'b0;
        m_br = 0; m_tk = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},        bus.pc,        m_pc);
        chk({tag, ".pc_plus4"},  bus.pc_plus4,  m_pc + 32'd4);
        chk({tag, ".link"},      bus.link_addr, m_pc + 32'd8);
        chk({tag, ".taken"},     32'(bus.taken),     32'(m_taken));
        chk({tag, ".addr_err"},  32'(bus.addr_err),  32'(m_err));
        chk({tag, ".err_pc"},    bus.err_pc,    m_err_pc);
        chk({tag, ".br_cnt"},    32'(bus.br_cnt),    32'(m_br));
        chk({tag, ".taken_cnt"}, 32'(bus.taken_cnt), 32'(m_tk));
    endtask

    // One clock: derive expected next state from the current inputs, step, compare.
    task automatic cycle(input string tag);
        logic [31:0] p4, nxt;
        logic        br, tk, red;
        int          off;
        p4 = m_pc + 32'd4; nxt = p4; br = 0; tk = 0; red = 0;
        case (bus.opcode)
            6'h04: begin br = 1; tk = bus.eq;  end
            6'h05: begin br = 1; tk = bus.ne;  end
            6'h06: begin br = 1; tk = bus.lez; end
            6'h07: begin br = 1; tk = bus.gtz; end
            6'h01: begin
                if (bus.rt == 5'd1)      begin br = 1; tk = bus.gez; end
                else if (bus.rt == 5'd0) begin br = 1; tk = bus.ltz; end
            end
            6'h02, 6'h03: begin red = 1; nxt = (p4 & 32'hF000_0000) | (32'(bus.target26) * 4); end
            6'h00: if (bus.funct == 6'h08) begin red = 1; nxt = bus.rs_val; end
            default: ;
        endcase
        if (br && tk) begin
            off = int'($signed(bus.imm16));
            red = 1;
            nxt = p4 + 32'(off * 4);
        end

        @(posedge clk);
        #1;
        m_taken = 1'b0;
        if (bus.err_clr) begin
            m_err = 1'b0;
        end else if (bus.pc_we && !m_err) begin
            if (nxt % 4 != 0) begin
                m_err = 1'b1;
                m_err_pc = m_pc;
            end else begin
                if (br) begin
                    if (m_br < CMAX) m_br++;
                    if (tk && m_tk < CMAX) m_tk++;
                end
                m_pc = nxt;
                m_taken = red;
            end
        end
        check_all(tag);
    endtask

    task automatic drive(input logic we, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rt, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic [31:0] rs,
                         input logic [5:0] flags, input logic clr);
        bus.pc_we = we; bus.opcode = op; bus.funct = fn; bus.rt = rt;
        bus.imm16 = imm; bus.target26 = tgt; bus.rs_val = rs;
        {bus.gtz, bus.ne, bus.eq, bus.gez, bus.lez, bus.ltz} = flags;
        bus.err_clr = clr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rs;
        int          pick;
        logic [5:0]  ops [9];
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08};

        rst_n = 1'b0;
        drive(0, 6'h00, 6'h00, 5'd0, 16'h0, 26'h0, 32'h0, 6'h00, 0);
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Three nops step the PC by 4 each.
        drive(1, 6'h00, 6'h00, 5'd0, 16'h0, 26'h0, 32'h0, 6'h00, 0);
        repeat (3) cycle("nop");
        chk("nop3_pc", bus.pc, 32'h0000_300C);

        // Back to 0x3000, then beq with offset -1 loops onto itself.
        drive(1, 6'h00, 6'h08, 5'd0, 16'h0, 26'h0, 32'h0000_3000, 6'h00, 0);
        cycle("jr_3000");
        drive(1, 6'h04, 6'h00, 5'd0, 16'hFFFF, 26'h0, 32'h0, 6'b001000, 0);
        cycle("beq_taken");
        chk("beq_taken_pc", bus.pc, 32'h0000_3000);
        chk("beq_taken_pulse", 32'(bus.taken), 32'd1);
        drive(0, 6'h04, 6'h00, 5'd0, 16'hFFFF, 26'h0, 32'h0, 6'b001000, 0);
        cycle("idle_after_beq");
        chk("taken_single_pulse", 32'(bus.taken), 32'd0);
        drive(1, 6'h04, 6'h00, 5'd0, 16'hFFFF, 26'h0, 32'h0, 6'b000000, 0);
        cycle("beq_not_taken");
        chk("beq_nt_pc", bus.pc, 32'h0000_3004);
        chk("beq_nt_br", 32'(bus.br_cnt), 32'd2);
        chk("beq_nt_tk", 32'(bus.taken_cnt), 32'd1);

        // j from 0x3FFC keeps pc_plus4's upper nibble.
        drive(1, 6'h00, 6'h08, 5'd0, 16'h0, 26'h0, 32'h0000_3FFC, 6'h00, 0);
        cycle("jr_3ffc");
        drive(1, 6'h02, 6'h00, 5'd0, 16'h0, 26'h0000400, 32'h0, 6'h3F, 0);
        cycle("j_1000");
        chk("j_pc", bus.pc, 32'h0000_1000);
        drive(1, 6'h00, 6'h08, 5'd0, 16'h0, 26'h0, 32'h0000_2000, 6'h3F, 0);
        cycle("jr_2000");
        chk("jr_pc", bus.pc, 32'h0000_2000);

        // Misaligned jr traps; commits are ignored until cleared.
        drive(1, 6'h00, 6'h08, 5'd0, 16'h0, 26'h0, 32'h0000_2002, 6'h00, 0);
        cycle("jr_misaligned");
        chk("err_flag", 32'(bus.addr_err), 32'd1);
        chk("err_pc", bus.err_pc, 32'h0000_2000);
        drive(1, 6'h02, 6'h00, 5'd0, 16'h0, 26'h0000123, 32'h0, 6'h00, 0);
        cycle("commit_while_err");
        drive(1, 6'h02, 6'h00, 5'd0, 16'h0, 26'h0000123, 32'h0, 6'h00, 1);
        cycle("clr_with_we");
        chk("clr_pc", bus.pc, 32'h0000_2000);
        chk("clr_flag", 32'(bus.addr_err), 32'd0);

        // Counter saturation with taken bltz.
        drive(0, 6'h00, 6'h00, 5'd0, 16'h0, 26'h0, 32'h0, 6'h00, 0);
        @(negedge clk); rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
        drive(1, 6'h01, 6'h00, 5'd0, 16'h0010, 26'h0, 32'h0, 6'b000001, 0);
        repeat (5) cycle("bltz_sat");
        chk("sat_br", 32'(bus.br_cnt), 32'd3);
        chk("sat_tk", 32'(bus.taken_cnt), 32'd3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rs = $urandom;
            if ($urandom_range(0, 9) != 0) rs[1:0] = 2'b00;
            pick = $urandom_range(0, 8);
            drive(($urandom_range(0, 3) != 0), ops[pick],
                  ($urandom_range(0, 1) != 0) ? 6'h08 : 6'(($urandom)),
                  5'($urandom_range(0, 2)), 16'($urandom), 26'($urandom), rs,
                  6'($urandom), ($urandom_range(0, 19) == 0));
            cycle("rand");
        end
        drive(0, 6'h00, 6'h00, 5'd0, 16'h0, 26'h0, 32'h0, 6'h00, 1);
        cycle("rand_clr");

        // Wrap past the top of memory, then async reset between edges.
        drive(1, 6'h00, 6'h08, 5'd0, 16'h0, 26'h0, 32'hFFFF_FFFC, 6'h00, 0);
        cycle("jr_top");
        drive(1, 6'h00, 6'h00, 5'd0, 16'h0, 26'h0, 32'h0, 6'h00, 0);
        cycle("wrap");
        chk("wrap_pc", bus.pc, 32'h0000_0000);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_pc", bus.pc, RST_PC);
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
